// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access unit: RV32I load/store funct3
// encodings, the access FSM state type and access-size decoding.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } mem_state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } mem_size_t;

  // Reserved encodings (011, 110, 111) fall through to word size.
  function automatic mem_size_t f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: f3_size = SZ_B;
      F3_H, F3_HU: f3_size = SZ_H;
      default:     f3_size = SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Combinational load-data formatter: selects the addressed byte/halfword lane
// of a bus word and sign- or zero-extends it according to funct3.
module load_formatter
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] fmt_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    fmt_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   fmt_data = {24'h0, byte_sel};
      F3_H:    fmt_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   fmt_data = {16'h0, half_sel};
      default: fmt_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: IDLE/WAIT/DONE handshake with a req/ack bus,
// store lane steering, load formatting and a WAIT timeout.
// Optional: define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] ex_mem_alu_result,
  input  logic [31:0] ex_mem_rs2_data,
  input  logic        ex_mem_mem_read,
  input  logic        ex_mem_mem_write,
  input  logic [2:0]  ex_mem_funct3,
  output logic [31:0] mem_mem_read_data,
  output logic        mem_stall,
  output logic        mem_bus_err,
  output logic        mem_misaligned,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_t       state_q, state_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic             bus_err_q, bus_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_load_q, is_load_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       off_q, off_d;

  logic [31:0] load_fmt;
  logic        access;
  logic        misaligned;
  mem_size_t   size;

  load_formatter u_load_formatter (
    .rdata    (dmem_rdata),
    .addr_lo  (off_q),
    .funct3   (f3_q),
    .fmt_data (load_fmt)
  );

  assign access = ex_mem_mem_read | ex_mem_mem_write;
  assign size   = f3_size(ex_mem_funct3);

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = ((size == SZ_H) && ex_mem_alu_result[0]) ||
                      ((size == SZ_W) && (ex_mem_alu_result[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    req_d          = req_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    be_d           = be_q;
    rd_data_d      = rd_data_q;
    bus_err_d      = 1'b0;
    cnt_d          = cnt_q;
    is_load_d      = is_load_q;
    f3_d           = f3_q;
    off_d          = off_q;
    mem_stall      = 1'b0;
    mem_misaligned = 1'b0;

    case (state_q)
      IDLE: begin
        mem_misaligned = access & misaligned;
        if (access && !misaligned) begin
          mem_stall = 1'b1;
          state_d   = WAIT;
          req_d     = 1'b1;
          we_d      = ex_mem_mem_write;
          addr_d    = {ex_mem_alu_result[31:2], 2'b00};
          is_load_d = ~ex_mem_mem_write;
          f3_d      = ex_mem_funct3;
          off_d     = ex_mem_alu_result[1:0];
          cnt_d     = '0;
          if (ex_mem_mem_write) begin
            case (size)
              SZ_B: begin
                be_d    = 4'b0001 << ex_mem_alu_result[1:0];
                wdata_d = {4{ex_mem_rs2_data[7:0]}};
              end
              SZ_H: begin
                be_d    = 4'b0011 << {ex_mem_alu_result[1], 1'b0};
                wdata_d = {2{ex_mem_rs2_data[15:0]}};
              end
              default: begin
                be_d    = 4'b1111;
                wdata_d = ex_mem_rs2_data;
              end
            endcase
          end else begin
            be_d    = 4'b1111;
            wdata_d = ex_mem_rs2_data;
          end
        end else if (access && !ex_mem_mem_write) begin
          // Trapped load: no bus cycle, result forced to zero.
          rd_data_d = '0;
        end
      end

      WAIT: begin
        mem_stall = 1'b1;
        if (dmem_ack) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (is_load_q) rd_data_d = load_fmt;
        end else if (cnt_q == CNT_LAST) begin
          req_d     = 1'b0;
          state_d   = DONE;
          bus_err_d = 1'b1;
          if (is_load_q) rd_data_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rd_data_q <= '0;
      bus_err_q <= 1'b0;
      cnt_q     <= '0;
      is_load_q <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      rd_data_q <= rd_data_d;
      bus_err_q <= bus_err_d;
      cnt_q     <= cnt_d;
      is_load_q <= is_load_d;
      f3_q      <= f3_d;
      off_q     <= off_d;
    end
  end

  assign dmem_req          = req_q;
  assign dmem_we           = we_q;
  assign dmem_addr         = addr_q;
  assign dmem_wdata        = wdata_q;
  assign dmem_be           = be_q;
  assign mem_mem_read_data = rd_data_q;
  assign mem_bus_err       = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: transaction-level reference model checked every
// cycle, plus directed accesses with hand-computed expected results.
module tb_mem_access_unit;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] ex_mem_alu_result;
  logic [31:0] ex_mem_rs2_data;
  logic        ex_mem_mem_read;
  logic        ex_mem_mem_write;
  logic [2:0]  ex_mem_funct3;
  logic [31:0] mem_mem_read_data;
  logic        mem_stall;
  logic        mem_bus_err;
  logic        mem_misaligned;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk               (clk),
    .rstn              (rstn),
    .ex_mem_alu_result (ex_mem_alu_result),
    .ex_mem_rs2_data   (ex_mem_rs2_data),
    .ex_mem_mem_read   (ex_mem_mem_read),
    .ex_mem_mem_write  (ex_mem_mem_write),
    .ex_mem_funct3     (ex_mem_funct3),
    .mem_mem_read_data (mem_mem_read_data),
    .mem_stall         (mem_stall),
    .mem_bus_err       (mem_bus_err),
    .mem_misaligned    (mem_misaligned),
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_addr         (dmem_addr),
    .dmem_wdata        (dmem_wdata),
    .dmem_be           (dmem_be),
    .dmem_ack          (dmem_ack),
    .dmem_rdata        (dmem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int size_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic is_mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
    return (int'(a[1:0]) % size_bytes(f3)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] fmt(input logic [31:0] rd, input logic [2:0] f3, input int off);
    int          sb;
    logic [31:0] v;
    logic [31:0] mask;
    sb = size_bytes(f3);
    if (sb == 4) return rd;
    v    = rd >> (8 * off);
    mask = (32'h1 << (8 * sb)) - 32'h1;
    v    = v & mask;
    if (!f3[2] && v[8*sb-1]) v = v | ~mask;
    return v;
  endfunction

  int          m_phase;   // 0 idle, 1 waiting on bus, 2 completion cycle
  int          m_wcnt;
  logic        m_req, m_we, m_load, m_err;
  logic [31:0] m_addr, m_wdata, m_rd;
  logic [3:0]  m_be;
  logic [2:0]  m_f3;
  int          m_off;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_phase <= 0; m_wcnt <= 0; m_req <= 1'b0; m_err <= 1'b0; m_rd <= '0;
      m_we <= 1'b0; m_load <= 1'b0; m_addr <= '0; m_wdata <= '0; m_be <= '0;
      m_f3 <= '0; m_off <= 0;
    end else begin
      case (m_phase)
        0: begin
          m_err <= 1'b0;
          if ((ex_mem_mem_read || ex_mem_mem_write) && !is_mis(ex_mem_funct3, ex_mem_alu_result)) begin
            automatic int sb  = size_bytes(ex_mem_funct3);
            automatic int off = int'(ex_mem_alu_result[1:0]);
            automatic int eff = off - (off % sb);
            m_phase <= 1;
            m_wcnt  <= 1;
            m_req   <= 1'b1;
            m_we    <= ex_mem_mem_write;
            m_load  <= !ex_mem_mem_write;
            m_addr  <= ex_mem_alu_result & 32'hFFFF_FFFC;
            m_f3    <= ex_mem_funct3;
            m_off   <= eff;
            if (!ex_mem_mem_write) begin
              m_be    <= 4'hF;
              m_wdata <= ex_mem_rs2_data;
            end else begin
              m_be <= 4'((32'd1 << sb) - 32'd1) << eff;
              if (sb == 1)      m_wdata <= {24'h0, ex_mem_rs2_data[7:0]} * 32'h0101_0101;
              else if (sb == 2) m_wdata <= {16'h0, ex_mem_rs2_data[15:0]} * 32'h0001_0001;
              else              m_wdata <= ex_mem_rs2_data;
            end
          end else if (ex_mem_mem_read && !ex_mem_mem_write) begin
            m_rd <= '0;
          end
        end
        1: begin
          if (dmem_ack) begin
            m_phase <= 2; m_req <= 1'b0;
            if (m_load) m_rd <= fmt(dmem_rdata, m_f3, m_off);
          end else if (m_wcnt == int'(TO)) begin
            m_phase <= 2; m_req <= 1'b0; m_err <= 1'b1;
            if (m_load) m_rd <= '0;
          end else begin
            m_wcnt <= m_wcnt + 1;
          end
        end
        default: begin
          m_phase <= 0; m_err <= 1'b0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    automatic logic acc = ex_mem_mem_read | ex_mem_mem_write;
    automatic logic mis = acc & is_mis(ex_mem_funct3, ex_mem_alu_result) & (m_phase == 0);
    automatic logic exp_stall = (m_phase == 1) || ((m_phase == 0) && acc && !mis);
    chk("stall", 32'(mem_stall), 32'(exp_stall));
    chk("req", 32'(dmem_req), 32'(m_req));
    chk("bus_err", 32'(mem_bus_err), 32'(m_err));
    chk("misaligned", 32'(mem_misaligned), 32'(mis));
    chk("read_data", mem_mem_read_data, m_rd);
    if (m_req) begin
      chk("dmem_addr", dmem_addr, m_addr);
      chk("dmem_we", 32'(dmem_we), 32'(m_we));
      chk("dmem_be", 32'(dmem_be), 32'(m_be));
      chk("dmem_wdata", dmem_wdata, m_wdata);
    end
  end

  // ---------------- directed stimulus ----------------
  int          s_cnt, w_cnt;
  logic        d_err;
  logic [31:0] c_addr, c_wdata;
  logic [3:0]  c_be;
  logic        c_we;

  // Entered just after a posedge with the DUT idle; ack_after = WAIT cycle
  // index on which ack is driven (0 = never).
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] rs2,
                        input int ack_after, input logic [31:0] rdata);
    ex_mem_mem_read   = rd;
    ex_mem_mem_write  = wr;
    ex_mem_funct3     = f3;
    ex_mem_alu_result = a;
    ex_mem_rs2_data   = rs2;
    dmem_rdata        = rdata;
    s_cnt = 0;
    @(negedge clk);
    if (mem_stall) s_cnt++;
    @(posedge clk); #1;
    w_cnt = 0;
    for (int k = 1; k <= 16; k++) begin
      w_cnt    = k;
      dmem_ack = (k == ack_after);
      @(negedge clk);
      if (mem_stall) s_cnt++;
      if (k == 1) begin
        c_addr = dmem_addr; c_wdata = dmem_wdata; c_be = dmem_be; c_we = dmem_we;
      end
      @(posedge clk); #1;
      if (dmem_ack || k == int'(TO)) break;
    end
    dmem_ack         = 1'b0;
    ex_mem_mem_read  = 1'b0;
    ex_mem_mem_write = 1'b0;
    @(negedge clk);
    if (mem_stall) s_cnt++;
    d_err = mem_bus_err;
    @(posedge clk); #1;
  endtask

  initial begin
    rstn = 1'b0;
    ex_mem_alu_result = '0; ex_mem_rs2_data = '0; ex_mem_mem_read = 1'b0;
    ex_mem_mem_write = 1'b0; ex_mem_funct3 = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    #12;
    chk("rst_req", 32'(dmem_req), 32'h0);
    chk("rst_be", 32'(dmem_be), 32'h0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk("rst_rdata", mem_mem_read_data, 32'h0);
    chk("rst_stall", 32'(mem_stall), 32'h0);
    @(posedge clk); #1 rstn = 1'b1;
    @(posedge clk); #1;

    // LB with sign extension, ack on 2nd WAIT cycle
    access(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 2, 32'h80FF_FF12);
    chk("lb_data", mem_mem_read_data, 32'hFFFF_FF80);
    chk("lb_stall_cycles", 32'(s_cnt), 32'd3);
    chk("lb_err", 32'(d_err), 32'h0);

    // SH upper halfword
    access(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 1, 32'h0);
    chk("sh_be", 32'(c_be), 32'hC);
    chk("sh_wdata", c_wdata, 32'hABCD_ABCD);
    chk("sh_addr", c_addr, 32'h0000_2000);
    chk("sh_we", 32'(c_we), 32'h1);
    chk("sh_keeps_rdata", mem_mem_read_data, 32'hFFFF_FF80);

    // LW, ack never arrives
    access(1'b1, 1'b0, 3'b010, 32'h0000_1000, 32'h0, 0, 32'h5555_5555);
    chk("to_wait_cycles", 32'(w_cnt), 32'd4);
    chk("to_err", 32'(d_err), 32'h1);
    chk("to_rdata", mem_mem_read_data, 32'h0);

`ifdef MEM_MISALIGN_TRAP_EN
    ex_mem_mem_read = 1'b1; ex_mem_funct3 = 3'b010; ex_mem_alu_result = 32'h0000_3001;
    @(negedge clk);
    chk("mis_flag", 32'(mem_misaligned), 32'h1);
    chk("mis_stall", 32'(mem_stall), 32'h0);
    @(posedge clk); #1;
    ex_mem_mem_read = 1'b0;
    chk("mis_req", 32'(dmem_req), 32'h0);
    chk("mis_rdata", mem_mem_read_data, 32'h0);
`else
    access(1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'h0, 1, 32'h1234_5678);
    chk("lw_mis_addr", c_addr, 32'h0000_3000);
    chk("lw_mis_data", mem_mem_read_data, 32'h1234_5678);
`endif

    access(1'b1, 1'b0, 3'b100, 32'h0000_1001, 32'h0, 1, 32'h1122_8344);
    chk("lbu_data", mem_mem_read_data, 32'h0000_0083);
    access(1'b1, 1'b0, 3'b001, 32'h0000_1002, 32'h0, 3, 32'h8001_7FFF);
    chk("lh_data", mem_mem_read_data, 32'hFFFF_8001);
    access(1'b1, 1'b0, 3'b101, 32'h0000_1000, 32'h0, 1, 32'h8001_F00D);
    chk("lhu_data", mem_mem_read_data, 32'h0000_F00D);

    access(1'b0, 1'b1, 3'b000, 32'h0000_4001, 32'h1234_565A, 1, 32'h0);
    chk("sb_be", 32'(c_be), 32'h2);
    chk("sb_wdata", c_wdata, 32'h5A5A_5A5A);

    // read+write together behaves as a store
    access(1'b1, 1'b1, 3'b010, 32'h0000_5000, 32'hDEAD_BEEF, 1, 32'hFFFF_FFFF);
    chk("rw_we", 32'(c_we), 32'h1);
    chk("rw_wdata", c_wdata, 32'hDEAD_BEEF);
    chk("rw_keeps_rdata", mem_mem_read_data, 32'h0000_F00D);

    // reserved funct3 as word, ack on the timeout cycle wins
    access(1'b1, 1'b0, 3'b011, 32'h0000_6000, 32'h0, 4, 32'hCAFE_BABE);
    chk("ack_at_to_data", mem_mem_read_data, 32'hCAFE_BABE);
    chk("ack_at_to_err", 32'(d_err), 32'h0);

    // reset in the middle of WAIT, then a stray ack
    ex_mem_mem_read = 1'b1; ex_mem_funct3 = 3'b010; ex_mem_alu_result = 32'h0000_7000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_req", 32'(dmem_req), 32'h1);
    #2 rstn = 1'b0; ex_mem_mem_read = 1'b0;
    #1;
    chk("rst_wait_req", 32'(dmem_req), 32'h0);
    chk("rst_wait_stall", 32'(mem_stall), 32'h0);
    @(posedge clk); #1 rstn = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1 dmem_ack = 1'b0;
    chk("late_ack_req", 32'(dmem_req), 32'h0);
    chk("late_ack_rdata", mem_mem_read_data, 32'h0);
    chk("late_ack_stall", 32'(mem_stall), 32'h0);
    repeat (3) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: WAIT-state cycles without dmem_ack before abort.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port ex_mem_alu_result  input  32  effective byte address from EX/MEM.
REQ-005 SHALL have port ex_mem_rs2_data  input  32  store data, unaligned in bits [7:0]/[15:0]/[31:0].
REQ-006 SHALL have port ex_mem_mem_read  input  1  load request.
REQ-007 SHALL have port ex_mem_mem_write  input  1  store request; read and write both high is treated as a store.
REQ-008 SHALL have port ex_mem_funct3  input  3  access size/sign (RV32I load/store funct3).
REQ-009 SHALL have port mem_mem_read_data  output  32  formatted load result, consumed by MEM/WB.
REQ-010 SHALL have port mem_stall  output  1  freezes PC, IF/ID, ID/EX, EX/MEM, MEM/WB while high.
REQ-011 SHALL have port mem_bus_err  output  1  one-cycle pulse in DONE when a timeout occurred.
REQ-012 SHALL have port mem_misaligned  output  1  misaligned access flag (see REQ-030).
REQ-013 SHALL have ports dmem_req output 1, dmem_we output 1, dmem_addr output 32 (bits [1:0]=0), dmem_wdata output 32, dmem_be output 4, dmem_ack input 1, dmem_rdata input 32.

Function
REQ-014 SHALL implement states IDLE, WAIT, DONE.
REQ-015 IDLE: access = read|write and not trapped-misaligned; if access, mem_stall=1 combinationally and next state WAIT; else mem_stall=0, stay IDLE.
REQ-016 On IDLE->WAIT SHALL register dmem_addr={addr[31:2],2'b00}, dmem_we, dmem_be, dmem_wdata and set dmem_req=1 (registered; request visible one cycle after acceptance).
REQ-017 WAIT: dmem_req and all dmem_* outputs SHALL be held stable; mem_stall=1.
REQ-018 dmem_ack SHALL be sampled only in WAIT; ack in WAIT -> dmem_req=0 next cycle, state DONE; loads capture formatted dmem_rdata into mem_mem_read_data.
REQ-019 Timeout counter SHALL clear on WAIT entry, increment each WAIT cycle; at TIMEOUT_CYCLES without ack -> dmem_req=0, mem_mem_read_data=0 for loads, mem_bus_err=1 in DONE, state DONE.
REQ-020 Ack arriving on the same cycle as timeout SHALL win (normal completion, no bus_err).
REQ-021 DONE: mem_stall=0 for exactly one cycle so MEM/WB captures; next state IDLE unconditionally; new access is not accepted in DONE.
REQ-022 Store byte enables: SB be=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}; SH be=4'b0011<<{addr[1],1'b0}, wdata={2{rs2[15:0]}}; SW be=4'b1111, wdata=rs2.
REQ-023 Loads: dmem_be=4'b1111, dmem_we=0.
REQ-024 Load formatting: LB/LBU select byte addr[1:0], LH/LHU select halfword addr[1]; LB/LH sign-extend, LBU/LHU zero-extend; LW passes word.
REQ-025 Reserved funct3 (011,110,111) SHALL be treated as word size.
REQ-026 mem_mem_read_data SHALL hold its value until the next load completes; stores do not modify it.
REQ-027 Back-to-back accesses SHALL take at least 3 cycles each (IDLE, WAIT>=1, DONE).

Reset
REQ-028 rstn low SHALL asynchronously force state IDLE, dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0, mem_mem_read_data=0, counter=0, mem_bus_err=0; mem_stall evaluates per IDLE rules.
REQ-029 Reset during WAIT SHALL drop dmem_req immediately; a late dmem_ack after release SHALL be ignored in IDLE.

Configuration
REQ-030 With MEM_MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1 or LW/SW with addr[1:0]!=0 SHALL assert mem_misaligned combinationally in IDLE, issue no bus request, no stall, load result 0.
REQ-031 Without MEM_MISALIGN_TRAP_EN: mem_misaligned tied 0; misaligned accesses proceed with lane selection per REQ-022/024 ignoring offending low bits (word: addr[1:0], half: addr[0]).

Structure
REQ-032 Package mem_pkg SHALL hold funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the state enum typedef mem_state_t.
REQ-033 Sub-module load_formatter (combinational: rdata, addr[1:0], funct3 -> formatted word) SHALL be instantiated once.

Verification
REQ-034 LB addr 0x1003, rdata 0x80FF_FF12, ack after 2 WAIT cycles -> read_data 0xFFFF_FF80, stall high 3 cycles then low 1.
REQ-035 SH addr 0x2002, rs2 0x0000_ABCD -> dmem_be 4'b1100, wdata 0xABCD_ABCD, addr 0x2000, we=1.
REQ-036 LW with ack never asserted, TIMEOUT_CYCLES=4 -> req drops after 4 WAIT cycles, bus_err pulse, read_data 0.
REQ-037 rstn low mid-WAIT, then ack pulse after release -> dmem_req 0 immediately, state IDLE, read_data unchanged at 0.
REQ-038 MEM_MISALIGN_TRAP_EN, LW addr 0x3001 -> mem_misaligned=1, dmem_req stays 0, stall 0; without macro -> word at 0x3000 read.
